// File: rtl/cnn_pkg.sv
// cnn_pkg: shared row-state encoding and signed max-of-4 width rule (output width equals pixel width, no truncation)
package cnn_pkg;
  typedef enum logic {ROW_EVEN = 1'b0, ROW_ODD = 1'b1} row_state_t;
  function automatic int max4_width(input int w);
    return w;
  endfunction
endpackage

// File: rtl/pool_max4.sv
// pool_max4: combinational signed max of four pixels; a,b,c,d in, y = max out
module pool_max4 import cnn_pkg::*; #(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  input  logic signed [DATA_WIDTH-1:0] c,
  input  logic signed [DATA_WIDTH-1:0] d,
  output logic signed [max4_width(DATA_WIDTH)-1:0] y
);
  logic signed [DATA_WIDTH-1:0] ab, cd;
  always_comb begin
    ab = a > b ? a : b;
    cd = c > d ? c : d;
    y = ab > cd ? ab : cd;
  end
endmodule

// File: rtl/maxpool_ctrl.sv
// maxpool_ctrl: 2x2/stride-2 signed max pooling of a row-major pixel stream; in_data/in_valid/in_ready in, out_data/out_valid/out_ready out, frame_done pulses on the last pooled accept
module maxpool_ctrl import cnn_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  row_state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [DATA_WIDTH-1:0] linebuf [IMG_W];
  logic [DATA_WIDTH-1:0] pair;
  logic [DATA_WIDTH-1:0] win_max;
  logic out_last;
  logic in_fire;
  logic out_fire;
  logic win_done;
  logic col_end;
  logic row_end;
  assign in_ready = !(state == ROW_ODD && col[0] && out_valid && !out_ready);
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign col_end = col == CW'(IMG_W - 1);
  assign row_end = row == RW'(IMG_H - 1);
  assign win_done = in_fire && state == ROW_ODD && col[0];
  assign frame_done = out_fire && out_last;
  pool_max4 #(.DATA_WIDTH(DATA_WIDTH)) u_max (
    .a(linebuf[col - CW'(1)]),
    .b(linebuf[col]),
    .c(pair),
    .d(in_data),
    .y(win_max)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ROW_EVEN;
      col <= '0;
      row <= '0;
      pair <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      if (in_fire) begin
        col <= col_end ? '0 : col + CW'(1);
        row <= col_end ? (row_end ? '0 : row + RW'(1)) : row;
        state <= col_end ? (state == ROW_EVEN ? ROW_ODD : ROW_EVEN) : state;
        pair <= state == ROW_ODD && !col[0] ? in_data : pair;
      end
      if (win_done) begin
        out_data <= win_max;
        out_valid <= 1'b1;
        out_last <= row_end && col_end;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (in_fire && state == ROW_EVEN) linebuf[col] <= in_data;
  end
endmodule

// File: doc/maxpool_ctrl.md
MAXPOOL_CTRL -- requirements
Module: maxpool_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning pixel width (signed two's complement fixed point).
REQ-002 SHALL have parameter IMG_W, default 28, meaning input feature-map width in pixels (even, >=2).
REQ-003 SHALL have parameter IMG_H, default 28, meaning input feature-map height in rows (even, >=2).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset sampled on clk.
REQ-006 SHALL have port in_data, input, DATA_WIDTH, input pixel, row-major order.
REQ-007 SHALL have port in_valid, input, 1, in_data valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-009 SHALL have port out_data, output, DATA_WIDTH, pooled pixel.
REQ-010 SHALL have port out_valid, output, 1, out_data valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts out_data.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse when last pooled pixel of a frame is accepted.

Function
REQ-013 SHALL transfer input on in_valid && in_ready and output on out_valid && out_ready; no other event counts.
REQ-014 SHALL track col (0..IMG_W-1) and row (0..IMG_H-1) counters advanced per input transfer; col wraps to 0 and row increments at IMG_W-1; row wraps to 0 at IMG_H-1.
REQ-015 SHALL implement states ROW_EVEN (store pixels of even row into line buffer at index col) and ROW_ODD (consume odd row); ROW_EVEN->ROW_ODD on transfer at col=IMG_W-1, ROW_ODD->ROW_EVEN likewise.
REQ-016 In ROW_ODD at even col, SHALL hold the pixel in a pair register; at odd col SHALL compute signed max of linebuf[col-1], linebuf[col], pair register, in_data.
REQ-017 SHALL load that max into a single-entry output register with out_valid=1 in the cycle after the odd-col transfer (latency 1 cycle from last window pixel).
REQ-018 SHALL hold out_data/out_valid stable while out_valid && !out_ready.
REQ-019 SHALL drive in_ready=0 only when in ROW_ODD at odd col and out_valid && !out_ready; otherwise in_ready=1.
REQ-020 Simultaneous output accept and new window completion SHALL overwrite the output register with out_valid remaining 1 (no bubble).
REQ-021 Ties SHALL return the equal value; comparison SHALL be signed over full DATA_WIDTH; no truncation.
REQ-022 SHALL emit (IMG_W/2)*(IMG_H/2) outputs per frame; frame_done SHALL pulse with the accept of the output produced from row IMG_H-1, col IMG_W-1.
REQ-023 Back-to-back frames SHALL proceed without idle cycles; counters wrap per REQ-014.

Reset
REQ-024 On rst_n=0 at a clk edge: state=ROW_EVEN, col=0, row=0, out_valid=0, out_data=0, frame_done=0, pair register=0; in_ready=1 after reset deasserts.
REQ-025 Line buffer contents SHALL not require reset; reset mid-frame SHALL discard the partial frame and restart at row 0, col 0.

Structure
REQ-026 State encoding constants and the signed max-of-4 width rule SHALL live in shared package cnn_pkg.
REQ-027 The 4-input signed max SHALL be a combinational sub-module pool_max4 (parameter DATA_WIDTH); the line buffer is an IMG_W-entry register array inside maxpool_ctrl.

Verification
REQ-028 IMG_W=4, IMG_H=2, inputs 1..8, out_ready=1 -> outputs 6 then 8, frame_done with second accept.
REQ-029 Negative values: window {-5,-3,-9,-1} -> out_data=-1 (0xFFFF), not 0xFFF7.
REQ-030 out_ready=0 for 5 cycles while second window completes -> in_ready=0 at odd col, first output held stable, no output lost or duplicated.
REQ-031 rst_n=0 asserted mid ROW_ODD -> next cycle out_valid=0, then a full new frame yields correct outputs and count.
REQ-032 Two consecutive 28x28 frames, random in_valid/out_ready -> 196 outputs each matching reference model, exactly two frame_done pulses.
